// File: rtl/data_mem_responder.sv
// Load/store responder with fixed wait states and byte-lane RAM.
// Define MISALIGN_TRAP_EN to flag misaligned H/W accesses as errors instead of force-aligning them.
module data_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [2:0]        reqCtrl,
  input  logic [31:0]       reqWData,
  output logic              respValid,
  output logic [31:0]       respRData,
  output logic              respErr,
  output logic              busy
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              writeL;
  logic [ADDR_W-1:0] addrL;
  logic [2:0]        ctrlL;
  logic [31:0]       wdataL;

  logic [31:0]       mem [0:DEPTH-1];

  logic              curWrite;
  logic [ADDR_W-1:0] curAddr;
  logic [2:0]        curCtrl;
  logic [31:0]       curWData;
  logic [31:0]       curWord;
  logic [1:0]        effLane;
  logic [7:0]        selByte;
  logic [15:0]       selHalf;
  logic              ctrlErr;
  logic              misErr;
  logic              curErr;
  logic [31:0]       loadData;
  logic [31:0]       curResult;
  logic [3:0]        byteEn;
  logic [31:0]       wrData;

  // In IDLE the live request is decoded so a zero-wait access can respond on the accept edge.
  always_comb begin
    curWrite = (state == IDLE) ? reqWrite : writeL;
    curAddr  = (state == IDLE) ? reqAddr  : addrL;
    curCtrl  = (state == IDLE) ? reqCtrl  : ctrlL;
    curWData = (state == IDLE) ? reqWData : wdataL;
    curWord  = mem[curAddr[ADDR_W-1:2]];

    case (curCtrl)
      3'b000, 3'b001, 3'b010: ctrlErr = 1'b0;
      3'b100, 3'b101:         ctrlErr = curWrite;
      default:                ctrlErr = 1'b1;
    endcase

`ifdef MISALIGN_TRAP_EN
    misErr  = ((curCtrl[1:0] == 2'b01) && curAddr[0]) ||
              ((curCtrl[1:0] == 2'b10) && (curAddr[1:0] != 2'b00));
    effLane = curAddr[1:0];
`else
    misErr  = 1'b0;
    case (curCtrl[1:0])
      2'b01:   effLane = {curAddr[1], 1'b0};
      2'b10:   effLane = 2'b00;
      default: effLane = curAddr[1:0];
    endcase
`endif

    curErr = ctrlErr | misErr;

    case (effLane)
      2'd0:    selByte = curWord[7:0];
      2'd1:    selByte = curWord[15:8];
      2'd2:    selByte = curWord[23:16];
      default: selByte = curWord[31:24];
    endcase
    selHalf = effLane[1] ? curWord[31:16] : curWord[15:0];

    case (curCtrl)
      3'b000:  loadData = {{24{selByte[7]}}, selByte};
      3'b100:  loadData = {24'd0, selByte};
      3'b001:  loadData = {{16{selHalf[15]}}, selHalf};
      3'b101:  loadData = {16'd0, selHalf};
      3'b010:  loadData = curWord;
      default: loadData = 32'd0;
    endcase
    curResult = (curErr || curWrite) ? 32'd0 : loadData;

    case (curCtrl[1:0])
      2'b00: begin
        byteEn = 4'b0001 << effLane;
        wrData = {4{curWData[7:0]}};
      end
      2'b01: begin
        byteEn = effLane[1] ? 4'b1100 : 4'b0011;
        wrData = {2{curWData[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrData = curWData;
      end
    endcase
  end

  // Stores commit on the edge that leaves RESP, so a reset during the transaction drops them.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && writeL && !respErr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[addrL[ADDR_W-1:2]][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      writeL    <= 1'b0;
      addrL     <= '0;
      ctrlL     <= 3'd0;
      wdataL    <= 32'd0;
      reqReady  <= 1'b0;
      respValid <= 1'b0;
      respRData <= 32'd0;
      respErr   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!reqReady) begin
            reqReady <= 1'b1;
          end else if (reqValid) begin
            writeL   <= reqWrite;
            addrL    <= reqAddr;
            ctrlL    <= reqCtrl;
            wdataL   <= reqWData;
            reqReady <= 1'b0;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              respValid <= 1'b1;
              respRData <= curResult;
              respErr   <= curErr;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LAST;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            respValid <= 1'b1;
            respRData <= curResult;
            respErr   <= curErr;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          respValid <= 1'b0;
          respRData <= 32'd0;
          respErr   <= 1'b0;
          busy      <= 1'b0;
          reqReady  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one WAIT_CYCLES=1 instance and one zero-wait instance
// sharing request inputs. Honours MISALIGN_TRAP_EN the same way the design does.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWrite;
  logic [11:0] reqAddr;
  logic [2:0]  reqCtrl;
  logic [31:0] reqWData;

  logic        r0Ready, r0Valid, r0Err, r0Busy;
  logic [31:0] r0RData;
  logic        r1Ready, r1Valid, r1Err, r1Busy;
  logic [31:0] r1RData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(r0Ready), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqCtrl(reqCtrl), .reqWData(reqWData), .respValid(r0Valid),
    .respRData(r0RData), .respErr(r0Err), .busy(r0Busy)
  );

  data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(r1Ready), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqCtrl(reqCtrl), .reqWData(reqWData), .respValid(r1Valid),
    .respRData(r1RData), .respErr(r1Err), .busy(r1Busy)
  );

  function automatic logic rdyOf(input int sel);
    return (sel == 0) ? r0Ready : r1Ready;
  endfunction

  function automatic logic validOf(input int sel);
    return (sel == 0) ? r0Valid : r1Valid;
  endfunction

  // Issue one request; lat counts negedges from the accept edge to the first one showing respValid.
  task automatic doTxn(input int sel, input logic wr, input logic [11:0] a, input logic [2:0] c,
                       input logic [31:0] d, input logic hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic readySeen);
    int guard = 0;
    readySeen = 1'b0;
    rd = 'x;
    er = 1'bx;
    @(negedge clk);
    while (rdyOf(sel) !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout dut=%0d got=%b expected=1", sel, rdyOf(sel));
      lat = -1;
      return;
    end
    reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqCtrl = c; reqWData = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (hold) begin
        readySeen = readySeen | rdyOf(sel);
        reqAddr   = a;
        reqWData  = 32'h5555_5555;
        reqWrite  = 1'b1;
        reqCtrl   = 3'b010;
      end else begin
        reqValid = 1'b0;
      end
    end while (validOf(sel) !== 1'b1 && lat < 20);
    reqValid = 1'b0;
    if (validOf(sel) !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL resp_timeout dut=%0d got=%b expected=1", sel, validOf(sel));
      lat = -1;
      return;
    end
    rd = (sel == 0) ? r0RData : r1RData;
    er = (sel == 0) ? r0Err : r1Err;
  endtask

  task automatic test_reset();
    rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqCtrl = 3'b010; reqWData = '0;
    repeat (2) @(negedge clk);
    checks++; if (r0Ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b expected=0", r0Ready); end
    checks++; if (r0Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b expected=0", r0Valid); end
    checks++; if (r0RData !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata got=%h expected=0", r0RData); end
    checks++; if (r0Err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b expected=0", r0Err); end
    checks++; if (r0Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b expected=0", r0Busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (r0Ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset got=%b expected=1", r0Ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; logic rs;
    doTxn(0, 1'b1, 12'h010, 3'b010, 32'hDEAD_BEEF, 1'b0, rd, er, lat, rs);
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL store_latency got=%0d expected=2", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("[TB] FAIL store_resp got=%h/%b expected=0/0", rd, er); end
    doTxn(0, 1'b0, 12'h010, 3'b010, 32'd0, 1'b0, rd, er, lat, rs);
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL load_latency got=%0d expected=2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("[TB] FAIL load_word got=%h/%b expected=deadbeef/0", rd, er); end
    @(negedge clk);
    checks++; if (r0Valid !== 1'b0 || r0Busy !== 1'b0 || r0Ready !== 1'b1) begin
      errors++; $display("[TB] FAIL after_resp valid/busy/ready got=%b%b%b expected=001", r0Valid, r0Busy, r0Ready);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat; logic rs;
    doTxn(0, 1'b1, 12'h010, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    doTxn(0, 1'b1, 12'h013, 3'b000, 32'h1234_5680, 1'b0, rd, er, lat, rs);
    doTxn(0, 1'b0, 12'h013, 3'b000, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin errors++; $display("[TB] FAIL load_b got=%h/%b expected=ffffff80/0", rd, er); end
    doTxn(0, 1'b0, 12'h013, 3'b100, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("[TB] FAIL load_bu got=%h expected=00000080", rd); end
    doTxn(0, 1'b0, 12'h010, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("[TB] FAIL byte_lane_word got=%h expected=80000000", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat; logic rs;
    doTxn(0, 1'b1, 12'h020, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    doTxn(0, 1'b1, 12'h022, 3'b001, 32'hABCD_1234, 1'b0, rd, er, lat, rs);
    doTxn(0, 1'b0, 12'h022, 3'b001, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("[TB] FAIL load_h_hi got=%h expected=00001234", rd); end
    doTxn(0, 1'b1, 12'h020, 3'b001, 32'h0000_8001, 1'b0, rd, er, lat, rs);
    doTxn(0, 1'b0, 12'h020, 3'b001, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL load_h_lo got=%h expected=ffff8001", rd); end
    doTxn(0, 1'b0, 12'h020, 3'b101, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("[TB] FAIL load_hu got=%h expected=00008001", rd); end
    doTxn(0, 1'b0, 12'h020, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h1234_8001) begin errors++; $display("[TB] FAIL half_word got=%h expected=12348001", rd); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat; logic rs;
    doTxn(0, 1'b0, 12'h020, 3'b011, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("[TB] FAIL illegal_load got=%h/%b expected=0/1", rd, er); end
    doTxn(0, 1'b1, 12'h020, 3'b100, 32'hFFFF_FFFF, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("[TB] FAIL illegal_store_bu got=%h/%b expected=0/1", rd, er); end
    doTxn(0, 1'b1, 12'h020, 3'b111, 32'hFFFF_FFFF, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL illegal_store_111 got=%b expected=1", er); end
    doTxn(0, 1'b0, 12'h020, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h1234_8001 || er !== 1'b0) begin errors++; $display("[TB] FAIL illegal_no_write got=%h/%b expected=12348001/0", rd, er); end
  endtask

  task automatic test_busy_hold();
    logic [31:0] rd; logic er; int lat; logic rs;
    doTxn(0, 1'b1, 12'h040, 3'b010, 32'hCAFE_F00D, 1'b1, rd, er, lat, rs);
    checks++; if (rs !== 1'b0) begin errors++; $display("[TB] FAIL ready_while_busy got=%b expected=0", rs); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL hold_latency got=%0d expected=2", lat); end
    doTxn(0, 1'b0, 12'h040, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL held_ignored got=%h expected=cafef00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic rs; logic sawValid;
    doTxn(0, 1'b1, 12'h030, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 12'h030; reqCtrl = 3'b010; reqWData = 32'h1111_1111;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (r0Busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy got=%b expected=1", r0Busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (4) begin
      sawValid = sawValid | r0Valid;
      @(negedge clk);
    end
    checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_resp got=%b expected=0", sawValid); end
    doTxn(0, 1'b0, 12'h030, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_discard got=%h expected=00000000", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat; logic rs;
`ifdef MISALIGN_TRAP_EN
    doTxn(0, 1'b0, 12'h031, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("[TB] FAIL misalign_w got=%h/%b expected=0/1", rd, er); end
    doTxn(0, 1'b1, 12'h021, 3'b001, 32'h0000_7777, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL misalign_h_store got=%b expected=1", er); end
    doTxn(0, 1'b0, 12'h020, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h1234_8001) begin errors++; $display("[TB] FAIL misalign_no_write got=%h expected=12348001", rd); end
`else
    doTxn(0, 1'b0, 12'h011, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b0 || rd !== 32'h8000_0000) begin errors++; $display("[TB] FAIL align_w got=%h/%b expected=80000000/0", rd, er); end
    doTxn(0, 1'b0, 12'h023, 3'b001, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (er !== 1'b0 || rd !== 32'h0000_1234) begin errors++; $display("[TB] FAIL align_h got=%h/%b expected=00001234/0", rd, er); end
    doTxn(0, 1'b1, 12'h021, 3'b001, 32'h0000_7777, 1'b0, rd, er, lat, rs);
    doTxn(0, 1'b0, 12'h020, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h1234_7777) begin errors++; $display("[TB] FAIL align_h_store got=%h expected=12347777", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; logic rs;
    doTxn(1, 1'b1, 12'h004, 3'b010, 32'hA5A5_A5A5, 1'b0, rd, er, lat, rs);
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL zw_store_latency got=%0d expected=1", lat); end
    doTxn(1, 1'b0, 12'h004, 3'b010, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (lat != 1 || rd !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL zw_load got=%h lat=%0d expected=a5a5a5a5 lat=1", rd, lat); end
    doTxn(1, 1'b0, 12'h007, 3'b100, 32'h0, 1'b0, rd, er, lat, rs);
    checks++; if (rd !== 32'h0000_00A5 || er !== 1'b0) begin errors++; $display("[TB] FAIL zw_load_bu got=%h/%b expected=000000a5/0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_busy_hold();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
